adc_sine_monitor: RTL and testbench

//  Consumes the digitised output codes of the SAR-ADC model while it is driven by the differential sine stimulus.

---
 rtl/adc_mon_pkg.sv | 13 +
 rtl/adc_sine_monitor_if.sv | 22 ++
 rtl/adc_mon_xdet.sv | 25 ++
 rtl/adc_sine_monitor.sv | 106 ++++++++++
 tb/tb_adc_sine_monitor.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/adc_mon_pkg.sv
// adc_mon_pkg: shared state type and width helpers for the ADC sine monitor.
package adc_mon_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} adc_mon_state_t;
  function automatic int mid_code(input int code_w);
    return 1 << (code_w - 1);
  endfunction
  function automatic int sum_w(input int code_w, input int win_log2);
    return code_w + win_log2;
  endfunction
  function automatic int sq_w(input int code_w, input int win_log2);
    return 2 * code_w + win_log2;
  endfunction
endpackage

// File: rtl/adc_sine_monitor_if.sv
// adc_sine_monitor_if: capture control, sample stream and result bus of the ADC sine monitor.
interface adc_sine_monitor_if #(parameter int CODE_W = 9, parameter int WIN_LOG2 = 10);
  logic                         start;
  logic                         code_valid;
  logic [CODE_W-1:0]            code_in;
  logic                         busy;
  logic                         done;
  logic [CODE_W-1:0]            code_min;
  logic [CODE_W-1:0]            code_max;
  logic [CODE_W-1:0]            code_mean;
  logic [WIN_LOG2:0]            rise_cnt;
  logic [WIN_LOG2-1:0]          rise_span;
  logic [2*CODE_W+WIN_LOG2-1:0] sq_sum;
  modport master (
    output start, code_valid, code_in,
    input  busy, done, code_min, code_max, code_mean, rise_cnt, rise_span, sq_sum
  );
  modport slave (
    input  start, code_valid, code_in,
    output busy, done, code_min, code_max, code_mean, rise_cnt, rise_span, sq_sum
  );
endinterface

// File: rtl/adc_mon_xdet.sv
// adc_mon_xdet: hysteresis mid-code crossing detector; rise is a same-cycle pulse on LOW->HIGH.
module adc_mon_xdet import adc_mon_pkg::*; #(
  parameter int CODE_W = 9,
  parameter int HYST   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] sample,
  input  logic              valid,
  input  logic              first,
  output logic              rise,
  output logic              pol
);
  localparam int MID = mid_code(CODE_W);
  localparam logic [CODE_W:0] HI = (CODE_W+1)'(MID + HYST);
  localparam logic [CODE_W:0] LO = (CODE_W+1)'(MID - HYST);
  localparam logic [CODE_W:0] MD = (CODE_W+1)'(MID);
  logic [CODE_W:0] s;
  assign s = {1'b0, sample};
  assign rise = valid && !first && !pol && s >= HI;
  // HIGH persists until the code falls to MID-HYST; LOW only leaves via a counted rise
  always_ff @(posedge clock or posedge reset)
    if (reset) pol <= 1'b0;
    else if (valid) pol <= first ? (s >= MD) : (pol ? (s > LO) : rise);
endmodule

// File: rtl/adc_sine_monitor.sv
// adc_sine_monitor: windowed min/max/mean/rising-crossing statistics of ADC codes.
// Define ADC_MON_SQSUM_EN to also accumulate the sum of squared codes into sq_sum.
module adc_sine_monitor import adc_mon_pkg::*; #(
  parameter int CODE_W   = 9,
  parameter int WIN_LOG2 = 10,
  parameter int HYST     = 4
) (
  input logic               clock,
  input logic               reset,
  adc_sine_monitor_if.slave bus
);
  localparam int SUM_W = sum_w(CODE_W, WIN_LOG2);
  localparam int SQ_W  = sq_w(CODE_W, WIN_LOG2);
  adc_mon_state_t      state;
  logic [WIN_LOG2-1:0] idx, first_idx, last_idx, first_idx_n, last_idx_n;
  logic [SUM_W-1:0]    sum, sum_n;
  logic [CODE_W-1:0]   mn, mx, mn_n, mx_n;
  logic [WIN_LOG2:0]   rc, rc_n;
  logic                first, rise, pol_unused, take, last;
  assign take = state == CAPTURE && bus.code_valid;
  assign last = take && &idx;
  adc_mon_xdet #(.CODE_W(CODE_W), .HYST(HYST)) u_xdet (
    .clock(clock), .reset(reset), .sample(bus.code_in), .valid(take), .first(first),
    .rise(rise), .pol(pol_unused)
  );
  // next-value stats let the final sample land in the results on the same edge
  always_comb begin
    sum_n       = sum + SUM_W'(bus.code_in);
    mn_n        = bus.code_in < mn ? bus.code_in : mn;
    mx_n        = bus.code_in > mx ? bus.code_in : mx;
    rc_n        = rc + (WIN_LOG2+1)'(rise);
    first_idx_n = (rise && rc == '0) ? idx : first_idx;
    last_idx_n  = rise ? idx : last_idx;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      first_idx     <= '0;
      last_idx      <= '0;
      sum           <= '0;
      mn            <= '0;
      mx            <= '0;
      rc            <= '0;
      first         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.code_min  <= '0;
      bus.code_max  <= '0;
      bus.code_mean <= '0;
      bus.rise_cnt  <= '0;
      bus.rise_span <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state    <= CAPTURE;
          bus.busy <= 1'b1;
          sum      <= '0;
          idx      <= '0;
          rc       <= '0;
          mn       <= '1;
          mx       <= '0;
          first    <= 1'b1;
        end
        CAPTURE: if (take) begin
          sum       <= sum_n;
          mn        <= mn_n;
          mx        <= mx_n;
          rc        <= rc_n;
          first_idx <= first_idx_n;
          last_idx  <= last_idx_n;
          first     <= 1'b0;
          idx       <= idx + 1'b1;
          if (last) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.code_min  <= mn_n;
            bus.code_max  <= mx_n;
            bus.code_mean <= sum_n[SUM_W-1:WIN_LOG2];
            bus.rise_cnt  <= rc_n;
            bus.rise_span <= rc_n >= (WIN_LOG2+1)'(2) ? last_idx_n - first_idx_n : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ADC_MON_SQSUM_EN
  logic [2*CODE_W-1:0] sq;
  logic [SQ_W-1:0]     sq_acc, sq_n;
  assign sq   = bus.code_in * bus.code_in;
  assign sq_n = sq_acc + SQ_W'(sq);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sq_acc     <= '0;
      bus.sq_sum <= '0;
    end else if (state == IDLE && bus.start) sq_acc <= '0;
    else if (take) begin
      sq_acc <= sq_n;
      if (last) bus.sq_sum <= sq_n;
    end
`else
  assign bus.sq_sum = '0;
`endif
endmodule

// File: tb/tb_adc_sine_monitor.sv
// tb_adc_sine_monitor: directed vectors with hand-computed results for adc_sine_monitor (CODE_W=9, WIN_LOG2=4).
module tb_adc_sine_monitor;
  logic clock = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int d0;
  logic [8:0] pat [16];
  adc_sine_monitor_if #(.CODE_W(9), .WIN_LOG2(4)) bus ();
  adc_sine_monitor #(.CODE_W(9), .WIN_LOG2(4), .HYST(4)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [8:0] c);
    bus.code_valid = 1'b1;
    bus.code_in = c;
    @(posedge clock); #1;
    bus.code_valid = 1'b0;
  endtask

  task automatic begin_cap();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_pat();
    begin_cap();
    for (int i = 0; i < 16; i++) feed(pat[i]);
  endtask

  task automatic results(input string tag, input int mn, input int mx, input int mean,
                         input int rc, input int span);
    chk({tag, ".done"}, 32'(bus.done), 1);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".min"}, 32'(bus.code_min), mn);
    chk({tag, ".max"}, 32'(bus.code_max), mx);
    chk({tag, ".mean"}, 32'(bus.code_mean), mean);
    chk({tag, ".rise_cnt"}, 32'(bus.rise_cnt), rc);
    chk({tag, ".rise_span"}, 32'(bus.rise_span), span);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.code_valid = 1'b0;
    bus.code_in = '0;
    repeat (2) @(posedge clock); #1;
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.min", 32'(bus.code_min), 0);
    chk("rst.max", 32'(bus.code_max), 0);
    chk("rst.mean", 32'(bus.code_mean), 0);
    chk("rst.rise_cnt", 32'(bus.rise_cnt), 0);
    chk("rst.rise_span", 32'(bus.rise_span), 0);
    chk("rst.sq_sum", 32'(bus.sq_sum), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // constant 300; sample presented with start must be dropped
    bus.start = 1'b1;
    bus.code_valid = 1'b1;
    bus.code_in = 9'd0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.code_valid = 1'b0;
    chk("const.busy_on", 32'(bus.busy), 1);
    for (int i = 0; i < 15; i++) feed(9'd300);
    chk("const.no_early_done", 32'(bus.done), 0);
    feed(9'd300);
    results("const", 300, 300, 300, 0, 0);
`ifdef ADC_MON_SQSUM_EN
    chk("const.sq_sum", 32'(bus.sq_sum), 1440000);
`else
    chk("const.sq_sum", 32'(bus.sq_sum), 0);
`endif
    @(posedge clock); #1;
    chk("const.done_drop", 32'(bus.done), 0);
    chk("const.hold_min", 32'(bus.code_min), 300);

    // square wave 4x0 / 4x511: rises at idx 4 and 12
    for (int i = 0; i < 16; i++) pat[i] = ((i / 4) % 2) ? 9'd511 : 9'd0;
    run_pat();
    results("square", 0, 511, 255, 2, 8);
    @(posedge clock); #1;

    // 255/258 never clears MID+HYST
    for (int i = 0; i < 16; i++) pat[i] = (i % 2) ? 9'd258 : 9'd255;
    run_pat();
    results("alt258", 255, 258, 256, 0, 0);
    @(posedge clock); #1;

    // 255/260 rises once; 255 stays above MID-HYST so it never re-arms
    for (int i = 0; i < 16; i++) pat[i] = (i % 2) ? 9'd260 : 9'd255;
    run_pat();
    results("alt260", 255, 260, 257, 1, 0);
    @(posedge clock); #1;

    // 252/260 touches both thresholds: rises at idx 1,3,...,15
    for (int i = 0; i < 16; i++) pat[i] = (i % 2) ? 9'd260 : 9'd252;
    run_pat();
    results("alt252", 252, 260, 256, 8, 14);
    @(posedge clock); #1;

    // constant 3: squared sum
    for (int i = 0; i < 16; i++) pat[i] = 9'd3;
    run_pat();
    results("three", 3, 3, 3, 0, 0);
`ifdef ADC_MON_SQSUM_EN
    chk("three.sq_sum", 32'(bus.sq_sum), 144);
`else
    chk("three.sq_sum", 32'(bus.sq_sum), 0);
`endif
    @(posedge clock); #1;

    // reset after 7 samples clears everything and emits no done
    d0 = done_cnt;
    begin_cap();
    for (int i = 0; i < 7; i++) feed(9'd400);
    reset = 1'b1;
    #1;
    chk("abort.busy", 32'(bus.busy), 0);
    chk("abort.done", 32'(bus.done), 0);
    chk("abort.min", 32'(bus.code_min), 0);
    chk("abort.max", 32'(bus.code_max), 0);
    chk("abort.mean", 32'(bus.code_mean), 0);
    chk("abort.rise_cnt", 32'(bus.rise_cnt), 0);
    chk("abort.sq_sum", 32'(bus.sq_sum), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("abort.no_done", 32'(done_cnt - d0), 0);
    chk("abort.idle", 32'(bus.busy), 0);
    for (int i = 0; i < 16; i++) pat[i] = 9'(i * 32);
    run_pat();
    results("ramp", 0, 480, 240, 1, 0);
    @(posedge clock); #1;

    // start held through a gappy capture: exactly one done, no restart
    d0 = done_cnt;
    bus.start = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) bus.start = 1'b0;
      feed(i < 8 ? 9'd100 : 9'd400);
      if (i == 0) chk("gap.busy_held", 32'(bus.busy), 1);
      if (i != 15) repeat (3) @(posedge clock);
      if (i != 15) #1;
    end
    results("gap", 100, 400, 250, 1, 0);
    repeat (4) @(posedge clock); #1;
    chk("gap.single_done", 32'(done_cnt - d0), 1);
    chk("gap.no_restart", 32'(bus.busy), 0);
    begin_cap();
    chk("restart.busy", 32'(bus.busy), 1);
    for (int i = 0; i < 16; i++) feed(9'd5);
    results("restart", 5, 5, 5, 0, 0);
    @(posedge clock); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
